// File: rtl/num_entry_bcd_pkg.sv
// rtl/num_entry_bcd_pkg.sv - shared state encoding and digit constants for BCD number entry
package num_entry_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Wraps to 0 from 9 and from any out-of-range code.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/num_entry_bcd_btn_rise_detect.sv
// rtl/num_entry_bcd_btn_rise_detect.sv - one-cycle press pulse from a debounced button level
module btn_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);

    logic level_q;

    // History resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/num_entry_bcd.sv
// rtl/num_entry_bcd.sv - three-digit BCD entry with sequential BCD-to-binary conversion
module num_entry_bcd
    import num_entry_bcd_pkg::*;
#(
    parameter int OUT_W   = 8,
    parameter int MAX_VAL = 255,
    parameter int ACC_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_inc,
    input  logic             btn_sel,
    input  logic             btn_enter,
    output logic [3:0]       dig_ones,
    output logic [3:0]       dig_tens,
    output logic [3:0]       dig_hund,
    output logic [1:0]       sel,
    output logic             busy,
    output logic [OUT_W-1:0] num_out,
    output logic             num_valid,
    output logic             sat
);

    logic inc_p, sel_p, enter_p;

    btn_rise_detect u_inc   (.clk(clk), .rst(rst), .level(btn_inc),   .press(inc_p));
    btn_rise_detect u_sel   (.clk(clk), .rst(rst), .level(btn_sel),   .press(sel_p));
    btn_rise_detect u_enter (.clk(clk), .rst(rst), .level(btn_enter), .press(enter_p));

    state_t           state, state_next;
    logic [3:0]       digit [3];
    logic [1:0]       idx;
    logic [ACC_W-1:0] acc;
    logic [3:0]       cur_digit;
    logic [ACC_W-1:0] acc_next;
    logic             over_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (enter_p) state_next = ST_CONV;
            ST_CONV: if (idx == DIG_ONES) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_digit = 4'd0;
        case (idx)
            DIG_ONES: cur_digit = digit[0];
            DIG_TENS: cur_digit = digit[1];
            DIG_HUND: cur_digit = digit[2];
            default:  cur_digit = 4'd0;
        endcase
    end

    // acc*10 + digit, hundreds first; 999 is the largest value reached.
    assign acc_next = (acc << 3) + (acc << 1) + ACC_W'(cur_digit);
    assign over_max = (acc > ACC_W'(MAX_VAL));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) digit[i] <= 4'd0;
            sel       <= DIG_ONES;
            idx       <= DIG_ONES;
            acc       <= '0;
            num_out   <= '0;
            num_valid <= 1'b0;
            sat       <= 1'b0;
        end else begin
            num_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enter_p) begin
                        acc <= '0;
                        idx <= DIG_HUND;
                    end else begin
                        // inc targets the pre-advance selection when both arrive together
                        for (int i = 0; i < 3; i++) begin
                            if (inc_p && sel == 2'(i)) digit[i] <= bcd_inc(digit[i]);
                        end
                        if (sel_p) sel <= (sel >= DIG_HUND) ? DIG_ONES : sel + 2'd1;
                    end
                end
                ST_CONV: begin
                    acc <= acc_next;
                    idx <= idx - 2'd1;
                end
                ST_DONE: begin
                    num_out   <= over_max ? OUT_W'(MAX_VAL) : acc[OUT_W-1:0];
                    sat       <= over_max;
                    num_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dig_ones = digit[0];
    assign dig_tens = digit[1];
    assign dig_hund = digit[2];
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_num_entry_bcd.sv
// tb/tb_num_entry_bcd.sv - directed self-checking bench for num_entry_bcd
module tb_num_entry_bcd;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_inc, btn_sel, btn_enter;
    logic [3:0] dig_ones, dig_tens, dig_hund;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] num_out;
    logic       num_valid;
    logic       sat;

    int total = 0;
    int bad   = 0;

    num_entry_bcd #(.OUT_W(8), .MAX_VAL(255), .ACC_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_inc   (btn_inc),
        .btn_sel   (btn_sel),
        .btn_enter (btn_enter),
        .dig_ones  (dig_ones),
        .dig_tens  (dig_tens),
        .dig_hund  (dig_hund),
        .sel       (sel),
        .busy      (busy),
        .num_out   (num_out),
        .num_valid (num_valid),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_inc = 1'b0; btn_sel = 1'b0; btn_enter = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_inc();
        @(negedge clk) btn_inc = 1'b1;
        @(negedge clk) btn_inc = 1'b0;
    endtask

    task automatic press_sel();
        @(negedge clk) btn_sel = 1'b1;
        @(negedge clk) btn_sel = 1'b0;
    endtask

    // Resets, then edits ones/tens/hundreds and cycles sel back to ones.
    task automatic set_digits(input int h, input int t, input int o);
        do_reset();
        for (int i = 0; i < o; i++) press_inc();
        press_sel();
        for (int i = 0; i < t; i++) press_inc();
        press_sel();
        for (int i = 0; i < h; i++) press_inc();
        press_sel();
    endtask

    // Checks busy in cycles 1..4, num_valid only in cycle 5, and the result.
    task automatic do_convert(input string tag, input int exp_num, input int exp_sat);
        @(negedge clk) btn_enter = 1'b1;
        @(negedge clk) btn_enter = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk({tag, "_busy"}, busy, (c <= 4) ? 1 : 0);
            chk({tag, "_valid"}, num_valid, (c == 5) ? 1 : 0);
            if (c == 5) begin
                chk({tag, "_num"}, num_out, exp_num);
                chk({tag, "_sat"}, sat, exp_sat);
            end
            @(negedge clk);
        end
        chk({tag, "_valid_off"}, num_valid, 0);
    endtask

    task automatic count_valid(input int cycles, inout int n);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (num_valid) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        btn_inc = 1'b0; btn_sel = 1'b0; btn_enter = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_ones", dig_ones, 0);
        chk("rst_tens", dig_tens, 0);
        chk("rst_hund", dig_hund, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_num", num_out, 0);
        chk("rst_valid", num_valid, 0);
        chk("rst_sat", sat, 0);

        set_digits(1, 2, 8);
        chk("edit_ones", dig_ones, 8);
        chk("edit_tens", dig_tens, 2);
        chk("edit_hund", dig_hund, 1);
        chk("edit_sel", sel, 0);
        do_convert("c128", 128, 0);
        do_convert("c128_again", 128, 0);

        set_digits(9, 9, 9);
        do_convert("c999", 255, 1);
        set_digits(2, 5, 5);
        do_convert("c255", 255, 0);
        set_digits(2, 5, 6);
        do_convert("c256", 255, 1);
        set_digits(0, 0, 0);
        do_convert("c000", 0, 0);

        do_reset();
        for (int i = 0; i < 9; i++) press_inc();
        chk("wrap_nine", dig_ones, 9);
        press_inc();
        chk("wrap_zero", dig_ones, 0);
        press_sel();
        chk("sel_one", sel, 1);
        press_sel();
        chk("sel_two", sel, 2);
        press_sel();
        chk("sel_wrap", sel, 0);
        @(negedge clk) begin btn_inc = 1'b1; btn_sel = 1'b1; end
        @(negedge clk) begin btn_inc = 1'b0; btn_sel = 1'b0; end
        chk("both_ones", dig_ones, 1);
        chk("both_tens", dig_tens, 0);
        chk("both_sel", sel, 1);

        // enter with inc in the same cycle: edit dropped
        @(negedge clk) begin btn_enter = 1'b1; btn_inc = 1'b1; end
        @(negedge clk) begin btn_enter = 1'b0; btn_inc = 1'b0; end
        chk("enter_wins_tens", dig_tens, 0);
        chk("enter_wins_busy", busy, 1);
        n = 0;
        count_valid(8, n);
        chk("enter_wins_valid", n, 1);
        chk("enter_wins_num", num_out, 1);

        set_digits(1, 2, 8);
        @(negedge clk) btn_enter = 1'b1;
        @(negedge clk) btn_enter = 1'b0;
        @(negedge clk) begin btn_enter = 1'b1; btn_inc = 1'b1; btn_sel = 1'b1; end
        @(negedge clk) begin btn_enter = 1'b0; btn_inc = 1'b0; btn_sel = 1'b0; end
        n = 0;
        count_valid(15, n);
        chk("busy_ignore_valid", n, 1);
        chk("busy_ignore_num", num_out, 128);
        chk("busy_ignore_ones", dig_ones, 8);
        chk("busy_ignore_sel", sel, 0);

        @(negedge clk) btn_enter = 1'b1;
        n = 0;
        count_valid(20, n);
        btn_enter = 1'b0;
        count_valid(5, n);
        chk("held_enter_valid", n, 1);

        set_digits(0, 4, 2);
        @(negedge clk) btn_enter = 1'b1;
        @(negedge clk) btn_enter = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("abort_busy", busy, 0);
        n = 0;
        count_valid(10, n);
        chk("abort_valid", n, 0);
        chk("abort_num", num_out, 0);
        chk("abort_tens", dig_tens, 0);
        chk("abort_ones", dig_ones, 0);

        @(negedge clk) begin btn_inc = 1'b1; btn_sel = 1'b1; rst = 1'b1; end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        @(negedge clk) begin btn_inc = 1'b0; btn_sel = 1'b0; end
        @(negedge clk);
        chk("held_rst_ones", dig_ones, 0);
        chk("held_rst_sel", sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
